queue_rf_mc: RTL and testbench
==============================

Name: queue_rf_mc

Overview:
- Multi-channel FIFO: C independent logical queues, each N entries of W bits, statically partitioned in one shared register file (rf).
- One enqueue and one dequeue per cycle. Each targets any channel, selected by channel index.
- Adds over the single-queue block: per-channel flush, per-channel occupancy level, and registered overflow/underflow error pulses.
- Sits between multi-source producers and a shared arbiter/consumer that pops by selected channel.

Parameters:
- C, 4, number of channels. Power of 2, C >= 2.
- N, 16, entries per channel. Power of 2, N >= 2.
- W, 32, entry width in bits.
- Derived, not overridable: CH_W = $clog2(C); ADDR_W = $clog2(N); LVL_W = ADDR_W + 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_push  in  1  enqueue strobe.
- i_push_ch  in  CH_W  enqueue channel.
- i_push_dat  in  W  enqueue data.
- i_pop  in  1  dequeue strobe.
- i_pop_ch  in  CH_W  dequeue channel.
- o_pop_dat  out  W  head entry of channel i_pop_ch (combinational).
- i_flush  in  C  per-channel flush, bit c clears channel c.
- o_full_w  out  C  bit c set when channel c holds N entries.
- o_empty_w  out  C  bit c set when channel c holds 0 entries.
- o_level  out  C*LVL_W  flattened occupancy; channel c at [c*LVL_W +: LVL_W], range 0..N.
- o_err_ovf  out  1  registered pulse: push was dropped on a full channel.
- o_err_udf  out  1  registered pulse: pop was dropped on an empty channel.

Behaviour:
- Storage:
  - One rf of C*N words; physical address = {ch, ptr[ADDR_W-1:0]}.
  - Write is synchronous; read is combinational from {i_pop_ch, rd_ptr[i_pop_ch]}.
- Pointers:
  - Per channel, wr_ptr and rd_ptr of LVL_W bits; the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - level = wr_ptr - rd_ptr, modulo 2^LVL_W.
  - Pointers wrap naturally from N-1 to 0 with the MSB toggling. No other wrap logic.
- Reset (rst=1 at an edge):
  - All pointers go to 0, so o_empty_w = all ones, o_full_w = 0, o_level = 0, o_err_ovf = o_err_udf = 0.
  - rf contents are not reset. o_pop_dat is undefined while the selected channel is empty.
  - rst overrides push, pop and flush in the same cycle. Reset mid-stream discards all data.
- Push accepted when i_push=1 and any of the following holds:
  - channel not full, or
  - channel full and there is a same-cycle accepted pop on the same channel.
- Push on a full channel without a same-channel pop:
  - data is dropped, no state change;
  - o_err_ovf=1 on the next cycle.
- Pop accepted when i_pop=1 and the channel is not empty:
  - rd_ptr increments;
  - o_pop_dat in that cycle is the popped value (zero latency).
- Pop on an empty channel:
  - ignored, o_err_udf=1 on the next cycle;
  - a same-cycle push to that empty channel is NOT bypassed to the pop.
- Push and pop in the same cycle:
  - Same channel: level unchanged (or +1/-1 per acceptance rules above).
  - Different channels: both proceed independently.
- Flush:
  - i_flush[c]=1 sets rd_ptr[c] = wr_ptr[c] at the edge, so the channel becomes empty next cycle.
  - Same-cycle push or pop to channel c is ignored with no error.
  - Other channels are unaffected.
- Status outputs:
  - o_full_w, o_empty_w and o_level are combinational from registered pointers.
  - They reflect state after the last edge.
- Error outputs:
  - o_err_* are registered, one cycle wide per offending request.
  - They are cleared by reset or on any cycle without an offence.
- Verification assertions:
  - i_push_ch < C and i_pop_ch < C (always true when C is a power of 2).
  - level <= N per channel.

Test Plan:
- Ordering/isolation:
  - Stimulus: push 0xA0..0xA3 to ch0 and 0xB0..0xB3 to ch2 interleaved, then pop ch2 x4 and ch0 x4.
  - Required: pops return B0..B3 then A0..A3; ch1/ch3 stay empty throughout.
- Fill/wrap (N=16):
  - Stimulus: push 16 to ch1.
  - Required: o_full_w[1]=1, level=16.
  - Stimulus: pop 8, push 8, pop 16.
  - Required: data is in order across the pointer wrap; final o_empty_w[1]=1.
- Full simultaneous:
  - Stimulus: ch3 full; push 0x55 and pop on ch3 in the same cycle.
  - Required: push accepted, level stays 16, no o_err_ovf; 0x55 pops last.
- Errors:
  - Stimulus: push to full ch0.
  - Required: o_err_ovf=1 next cycle, level unchanged.
  - Stimulus: pop empty ch1.
  - Required: o_err_udf=1 next cycle.
- Flush:
  - Stimulus: ch0 level 5 and ch2 level 3; assert i_flush=4'b0001 with a push to ch0.
  - Required: next cycle ch0 empty (push ignored); ch2 level still 3, data intact.
- Reset mid-operation:
  - Stimulus: with several channels non-empty, pulse rst with push/pop active.
  - Required: next cycle all empty, levels 0, errors 0; subsequent push/pop behaves normally.

Source files
------------

// File: rtl/queue_rf_mc.sv
// queue_rf_mc: C independent FIFOs of N x W bits sharing one register file,
// with per-channel flush, occupancy levels and registered error pulses.
module queue_rf_mc #(
  parameter int unsigned C = 4,
  parameter int unsigned N = 16,
  parameter int unsigned W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_push,
  input  logic [$clog2(C)-1:0]              i_push_ch,
  input  logic [W-1:0]                      i_push_dat,
  input  logic                              i_pop,
  input  logic [$clog2(C)-1:0]              i_pop_ch,
  output logic [W-1:0]                      o_pop_dat,
  input  logic [C-1:0]                      i_flush,
  output logic [C-1:0]                      o_full_w,
  output logic [C-1:0]                      o_empty_w,
  output logic [C*($clog2(N)+1)-1:0]        o_level,
  output logic                              o_err_ovf,
  output logic                              o_err_udf
);

  localparam int unsigned CH_W   = $clog2(C);
  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned RF_AW  = CH_W + ADDR_W;

  logic [LVL_W-1:0] r_wr_ptr [C];
  logic [LVL_W-1:0] r_rd_ptr [C];
  logic [W-1:0]     r_rf     [C*N];

  logic [C-1:0]     w_full;
  logic [C-1:0]     w_empty;
  logic             w_push_flushed;
  logic             w_pop_flushed;
  logic             w_pop_acc;
  logic             w_push_acc;
  logic             w_ovf;
  logic             w_udf;
  logic [RF_AW-1:0] w_wr_addr;
  logic [RF_AW-1:0] w_rd_addr;

  // Per-channel status decoded from the registered pointer pair
  for (genvar g = 0; g < C; g++) begin : g_ch
    assign w_empty[g] = (r_wr_ptr[g] == r_rd_ptr[g]);
    assign w_full[g]  = (r_wr_ptr[g][ADDR_W-1:0] == r_rd_ptr[g][ADDR_W-1:0]) &&
                        (r_wr_ptr[g][ADDR_W] != r_rd_ptr[g][ADDR_W]);
    assign o_level[g*LVL_W +: LVL_W] = r_wr_ptr[g] - r_rd_ptr[g];
  end

  assign o_full_w  = w_full;
  assign o_empty_w = w_empty;

  // Request acceptance; a flushed channel silently ignores both requests
  always_comb begin
    w_push_flushed = i_flush[i_push_ch];
    w_pop_flushed  = i_flush[i_pop_ch];
    w_pop_acc      = i_pop && !w_pop_flushed && !w_empty[i_pop_ch];
    w_push_acc     = i_push && !w_push_flushed &&
                     (!w_full[i_push_ch] || (w_pop_acc && (i_pop_ch == i_push_ch)));
    w_ovf          = i_push && !w_push_flushed && !w_push_acc;
    w_udf          = i_pop && !w_pop_flushed && w_empty[i_pop_ch];
  end

  assign w_wr_addr = {i_push_ch, r_wr_ptr[i_push_ch][ADDR_W-1:0]};
  assign w_rd_addr = {i_pop_ch, r_rd_ptr[i_pop_ch][ADDR_W-1:0]};
  assign o_pop_dat = r_rf[w_rd_addr];

  // Shared storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_rf[w_wr_addr] <= i_push_dat;
    end
  end

  // Pointer update; flush snaps rd_ptr to wr_ptr, discarding the channel
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < C; c++) begin
      if (rst) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
      end else begin
        if (w_push_acc && (i_push_ch == CH_W'(c))) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + LVL_W'(1);
        end
        if (i_flush[c]) begin
          r_rd_ptr[c] <= r_wr_ptr[c];
        end else if (w_pop_acc && (i_pop_ch == CH_W'(c))) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + LVL_W'(1);
        end
      end
    end
  end

  // One-cycle error pulses for dropped requests
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_ovf <= 1'b0;
      o_err_udf <= 1'b0;
    end else begin
      o_err_ovf <= w_ovf;
      o_err_udf <= w_udf;
    end
  end

endmodule

// File: tb/tb_queue_rf_mc.sv
// tb_queue_rf_mc: directed and random stimulus against a queue-based model;
// expectations are queued per cycle and checked by an independent monitor.
module tb_queue_rf_mc;

  localparam int unsigned C     = 4;
  localparam int unsigned N     = 16;
  localparam int unsigned W     = 32;
  localparam int unsigned LVL_W = $clog2(N) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_push;
  logic [1:0]         i_push_ch;
  logic [W-1:0]       i_push_dat;
  logic               i_pop;
  logic [1:0]         i_pop_ch;
  logic [W-1:0]       o_pop_dat;
  logic [C-1:0]       i_flush;
  logic [C-1:0]       o_full_w;
  logic [C-1:0]       o_empty_w;
  logic [C*LVL_W-1:0] o_level;
  logic               o_err_ovf;
  logic               o_err_udf;

  queue_rf_mc #(.C(C), .N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_push     (i_push),
    .i_push_ch  (i_push_ch),
    .i_push_dat (i_push_dat),
    .i_pop      (i_pop),
    .i_pop_ch   (i_pop_ch),
    .o_pop_dat  (o_pop_dat),
    .i_flush    (i_flush),
    .o_full_w   (o_full_w),
    .o_empty_w  (o_empty_w),
    .o_level    (o_level),
    .o_err_ovf  (o_err_ovf),
    .o_err_udf  (o_err_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 chk_dat;
    logic [W-1:0]       dat;
    logic [C*LVL_W-1:0] lvl;
    logic [C-1:0]       emp;
    logic [C-1:0]       ful;
    bit                 ovf;
    bit                 udf;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mq[C][$];
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // One cycle of stimulus: drive, record expectation from pre-edge model, advance model
  task automatic step(input bit push, input logic [1:0] pch, input logic [W-1:0] pdat,
                      input bit pop, input logic [1:0] poch, input logic [C-1:0] fl,
                      input bit rs);
    exp_t e;
    bit   pa;
    bit   qa;
    @(posedge clk);
    #1;
    rst = rs; i_push = push; i_push_ch = pch; i_push_dat = pdat;
    i_pop = pop; i_pop_ch = poch; i_flush = fl;
    for (int c = 0; c < C; c++) begin
      e.lvl[c*LVL_W +: LVL_W] = LVL_W'(mq[c].size());
      e.emp[c] = (mq[c].size() == 0);
      e.ful[c] = (mq[c].size() == N);
    end
    e.ovf = m_ovf;
    e.udf = m_udf;
    pa = !rs && pop && !fl[poch] && (mq[poch].size() > 0);
    qa = !rs && push && !fl[pch] && ((mq[pch].size() < N) || (pa && (poch == pch)));
    e.chk_dat = pa;
    e.dat = pa ? mq[poch][0] : '0;
    if (rs) begin
      for (int c = 0; c < C; c++) mq[c].delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ovf = push && !fl[pch] && !qa;
      m_udf = pop && !fl[poch] && !pa;
      if (pa) void'(mq[poch].pop_front());
      if (qa) mq[pch].push_back(pdat);
      for (int c = 0; c < C; c++) if (fl[c]) mq[c].delete();
    end
    sb.push_back(e);
  endtask

  task automatic push_op(input logic [1:0] ch, input logic [W-1:0] d);
    step(1'b1, ch, d, 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic pop_op(input logic [1:0] ch);
    step(1'b0, 2'd0, '0, 1'b1, ch, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk_dat) check("pop_dat", 64'(o_pop_dat), 64'(mon_e.dat));
      check("level", 64'(o_level), 64'(mon_e.lvl));
      check("empty", 64'(o_empty_w), 64'(mon_e.emp));
      check("full", 64'(o_full_w), 64'(mon_e.ful));
      check("err_ovf", 64'(o_err_ovf), 64'(mon_e.ovf));
      check("err_udf", 64'(o_err_udf), 64'(mon_e.udf));
    end
  end

  initial begin
    int pop_bias;
    rst = 1'b1; i_push = 1'b0; i_push_ch = '0; i_push_dat = '0;
    i_pop = 1'b0; i_pop_ch = '0; i_flush = '0;
    repeat (2) @(posedge clk);

    // Reset state, then ordering/isolation across ch0 and ch2
    idle();
    for (int i = 0; i < 4; i++) begin
      push_op(2'd0, W'(32'hA0 + i));
      push_op(2'd2, W'(32'hB0 + i));
    end
    for (int i = 0; i < 4; i++) pop_op(2'd2);
    for (int i = 0; i < 4; i++) pop_op(2'd0);

    // Fill and wrap on ch1
    for (int i = 0; i < 16; i++) push_op(2'd1, W'(32'h100 + i));
    idle();
    for (int i = 0; i < 8; i++) pop_op(2'd1);
    for (int i = 0; i < 8; i++) push_op(2'd1, W'(32'h200 + i));
    for (int i = 0; i < 16; i++) pop_op(2'd1);
    idle();

    // Full channel with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_op(2'd3, W'(32'h300 + i));
    step(1'b1, 2'd3, W'(32'h55), 1'b1, 2'd3, '0, 1'b0);
    idle();
    for (int i = 0; i < 16; i++) pop_op(2'd3);
    idle();

    // Overflow on full ch0, underflow on empty ch1
    for (int i = 0; i < 16; i++) push_op(2'd0, W'(32'h400 + i));
    push_op(2'd0, W'(32'hDEAD));
    idle();
    pop_op(2'd1);
    idle();
    idle();

    // Flush ch0 with a same-cycle push while ch2 keeps its data
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) push_op(2'd0, W'(32'h500 + i));
    for (int i = 0; i < 3; i++) push_op(2'd2, W'(32'h600 + i));
    step(1'b1, 2'd0, W'(32'h77), 1'b0, 2'd0, 4'b0001, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) pop_op(2'd2);
    pop_op(2'd0);

    // Reset mid-stream with push and pop active
    for (int i = 0; i < 3; i++) begin
      push_op(2'd1, W'(32'h700 + i));
      push_op(2'd3, W'(32'h800 + i));
    end
    step(1'b1, 2'd1, W'(32'h99), 1'b1, 2'd3, '0, 1'b1);
    idle();
    push_op(2'd3, W'(32'h900));
    pop_op(2'd3);
    idle();

    // Randomized traffic with varying pop pressure, rare flush and reset
    for (int i = 0; i < 2000; i++) begin
      logic [C-1:0] fl;
      if ((i % 250) == 0) pop_bias = int'($urandom_range(1, 9));
      fl = ($urandom_range(0, 31) == 0) ? C'($urandom) : '0;
      step($urandom_range(0, 9) >= 3, 2'($urandom), W'($urandom),
           $urandom_range(0, 9) < pop_bias, 2'($urandom), fl,
           $urandom_range(0, 599) == 0);
    end
    idle();

    @(posedge clk);
    #1;
    i_push = 1'b0; i_pop = 1'b0; i_flush = '0; rst = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
